// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock, start/busy/done handshake.
// Optional SHIFT_SUB_DBZ_EN: divide-by-zero short-cut with a div_by_zero flag (1-cycle latency).
module shift_sub_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    stepCnt;
  logic [WIDTH-1:0] remR;
  logic [WIDTH-1:0] quoQ;
  logic [WIDTH-1:0] divB;

  logic [WIDTH:0]   shiftR;
  logic             fits;
  logic [WIDTH-1:0] nextR;
  logic [WIDTH-1:0] nextQ;

  // One restoring step; the stored remainder is always < b so WIDTH bits hold it between steps.
  always_comb begin
    shiftR = {remR, quoQ[WIDTH-1]};
    fits   = (shiftR >= {1'b0, divB});
    nextQ  = quoQ << 1;
    nextR  = WIDTH'(shiftR);
    if (fits) begin
      nextR    = WIDTH'(shiftR - {1'b0, divB});
      nextQ[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      stepCnt <= '0;
      remR    <= '0;
      quoQ    <= '0;
      divB    <= '0;
`ifdef SHIFT_SUB_DBZ_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remR    <= '0;
            quoQ    <= a;
            divB    <= b;
            stepCnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef SHIFT_SUB_DBZ_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef SHIFT_SUB_DBZ_EN
          // Zero divisor skips the iteration; quoQ still holds the dividend here.
          if (divB == '0) begin
            q           <= '1;
            r           <= quoQ;
            done        <= 1'b1;
            busy        <= 1'b0;
            div_by_zero <= 1'b1;
            state       <= IDLE;
          end else
`endif
          begin
            remR    <= nextR;
            quoQ    <= nextQ;
            stepCnt <= stepCnt + 1'b1;
            if (stepCnt == LAST_STEP) begin
              q     <= nextQ;
              r     <= nextR;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SHIFT_SUB_DBZ_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: arithmetic reference model plus directed literal cases.
module tb_shift_sub_divider;

  localparam int unsigned W = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef SHIFT_SUB_DBZ_EN
  localparam int DBZ_LAT = 1;
  localparam int DBZ_FLAG = 1;
`else
  localparam int DBZ_LAT = W;
  localparam int DBZ_FLAG = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic busy, done, dbz;
  logic [W-1:0] q, r;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: quotient/remainder by plain division, completion scheduled by latency.
  int remaining = 0;
  int expBusy = 0, expDone = 0, expQ = 0, expR = 0, expDbz = 0;
  int pQ = 0, pR = 0, pDbz = 0;

  always @(posedge clk) begin
    if (rst) begin
      remaining = 0;
      expBusy = 0; expDone = 0; expQ = 0; expR = 0; expDbz = 0;
    end else begin
      expDone = 0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          expQ = pQ; expR = pR; expDbz = pDbz;
          expDone = 1; expBusy = 0;
        end
      end else if (start) begin
        if (b == 0) begin
          pQ = MAXV; pR = int'(a); pDbz = DBZ_FLAG;
          remaining = DBZ_LAT;
        end else begin
          pQ = int'(a) / int'(b); pR = int'(a) % int'(b); pDbz = 0;
          remaining = W;
        end
        expBusy = 1;
        expDbz = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      chk("busy", int'(busy), expBusy);
      chk("done", int'(done), expDone);
      chk("q", int'(q), expQ);
      chk("r", int'(r), expR);
      chk("div_by_zero", int'(dbz), expDbz);
    end
  end

  // Launch one division, scramble inputs during RUN, and check latency and result literally.
  task automatic runOne(input int x, input int y, input int eq, input int er,
                        input int elat, input int edbz);
    int n;
    a = W'(x); b = W'(y); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
      a = W'($urandom); b = W'($urandom);
    end
    chk("latency", n, elat);
    chk("lit_q", int'(q), eq);
    chk("lit_r", int'(r), er);
    chk("lit_dbz", int'(dbz), edbz);
    @(posedge clk); #2;
    chk("done_falls", int'(done), 0);
    chk("q_held", int'(q), eq);
    chk("r_held", int'(r), er);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_dbz", int'(dbz), 0);
    checkEn = 1'b1;

    runOne(13, 4, 3, 1, 4, 0);
    runOne(15, 1, 15, 0, 4, 0);
    runOne(7, 9, 0, 7, 4, 0);
    runOne(15, 15, 1, 0, 4, 0);
    runOne(0, 5, 0, 0, 4, 0);
    runOne(9, 0, 15, 9, DBZ_LAT, DBZ_FLAG);

    // Exhaustive sweep: the model checks every result, the identity is checked here too.
    for (int x = 0; x <= MAXV; x++) begin
      for (int y = 1; y <= MAXV; y++) begin
        a = W'(x); b = W'(y); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (W) @(posedge clk);
        #2;
        checks++;
        if (!(int'(q) * y + int'(r) == x && int'(r) < y)) begin
          errors++;
          $display("FAIL identity %0d/%0d: got q=%0d r=%0d", x, y, q, r);
        end
      end
    end

    // Start held high with operands changing every cycle: back-to-back ops.
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a = W'($urandom); b = W'($urandom_range(0, MAXV));
      @(posedge clk); #2;
    end

    // Random start pulses.
    for (int i = 0; i < 300; i++) begin
      start = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #2;
    end
    start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #2;

    // Reset in the middle of a 13/4 operation, sampled at E2.
    a = 4'd13; b = 4'd4; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_q", int'(q), 0);
    chk("midrst_r", int'(r), 0);
    runOne(13, 4, 3, 1, 4, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
